// File: rtl/lsu_split.sv
// -----------------------------------------------------------------------------
// lsu_split
//
// Load/store sequencer sitting between the CPU memory stage and the data
// memory (dmem). One request is in flight at a time. A naturally aligned
// access goes to dmem as a single access with the original memop. A
// misaligned halfword or word access is broken into consecutive byte
// accesses. For loads, the returned bytes are merged into a buffer and
// extended before the response.
//
// dmem is assumed to have a registered read port: the address and memop
// presented in RD_ISSUE produce valid read data during RD_WAIT.
//
// Ports
//   clk         system clock (dmem rdclk/wrclk tied to it, rising edge)
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   request accepted when req_valid & req_ready
//   req_we      1 = store, 0 = load
//   req_memop   000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   resp_valid  one-cycle completion pulse (loads and stores)
//   resp_rdata  extended load result, 0 for stores and errors
//   resp_err    illegal memop, valid with resp_valid
//   mem_addr    dmem rdaddr/wraddr
//   mem_wdata   dmem datain
//   mem_memop   dmem memop
//   mem_we      dmem write enable
//   mem_rdata   dmem dataout
//   split_cnt   wrapping count of accepted legal misaligned requests
// -----------------------------------------------------------------------------
module lsu_split (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,

    output logic [31:0] split_cnt
);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured request
    logic        r_we;
    logic [2:0]  r_memop;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_split;
    logic        r_err;
    logic [1:0]  r_last;     // index of the final beat (n-1)
    logic [1:0]  r_k;        // current beat
    logic [31:0] r_buf;      // load data merge buffer
    logic [31:0] r_split_cnt;

    // Request decode
    logic        w_accept;
    logic        w_req_legal;
    logic        w_req_misalign;
    logic [1:0]  w_req_last;

    // Beat datapath
    logic [4:0]  w_byte_lsb;
    logic [31:0] w_beat_addr;
    logic [7:0]  w_beat_byte;
    logic [31:0] w_load_result;
    logic        w_last_beat;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // bu/hu only make sense for loads; 011/110/111 are never legal.
    function automatic logic memop_legal(input logic we, input logic [2:0] op);
        logic ok;
        case (op)
            OP_B, OP_H, OP_W: ok = 1'b1;
            OP_BU, OP_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] a);
        logic mis;
        case (op)
            OP_H, OP_HU: mis = a[0];
            OP_W:        mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Final beat index for a split access: 1 for halfwords, 3 for words.
    function automatic logic [1:0] split_last_beat(input logic [2:0] op);
        return (op == OP_W) ? 2'd3 : 2'd1;
    endfunction

    // Extension of a merged split load. Only h, hu and w can be split.
    function automatic logic [31:0] extend_split(input logic [31:0] b, input logic [2:0] op);
        logic signed [15:0] half_s;
        logic [31:0]        res;
        half_s = b[15:0];
        case (op)
            OP_H:    res = 32'(half_s);
            OP_HU:   res = {16'h0000, b[15:0]};
            default: res = b;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign req_ready      = (r_state == S_IDLE) & ~rst;
    assign w_accept       = req_valid & req_ready;
    assign w_req_legal    = memop_legal(req_we, req_memop);
    assign w_req_misalign = memop_misaligned(req_memop, req_addr[1:0]);
    assign w_req_last     = (w_req_legal & w_req_misalign) ? split_last_beat(req_memop) : 2'd0;

    assign w_last_beat    = (r_k == r_last);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_req_legal) begin
                        w_state_nxt = S_DONE;
                    end else if (req_we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:  w_state_nxt = w_last_beat ? S_DONE : S_RD_ISSUE;
            S_WR:       w_state_nxt = w_last_beat ? S_DONE : S_WR;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_memop     <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_split     <= 1'b0;
            r_err       <= 1'b0;
            r_last      <= 2'd0;
            r_k         <= 2'd0;
            r_buf       <= 32'h0;
            r_split_cnt <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_memop <= req_memop;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_split <= w_req_legal & w_req_misalign;
                        r_err   <= ~w_req_legal;
                        r_last  <= w_req_last;
                        r_k     <= 2'd0;
                        r_buf   <= 32'h0;
                        if (w_req_legal && w_req_misalign) begin
                            r_split_cnt <= r_split_cnt + 32'd1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Split beats return a zero-extended byte (bu) in [7:0].
                    if (r_split) begin
                        r_buf[w_byte_lsb +: 8] <= mem_rdata[7:0];
                    end else begin
                        r_buf <= mem_rdata;
                    end
                    r_k <= r_k + 2'd1;
                end
                S_WR: begin
                    r_k <= r_k + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // dmem drive
    // -------------------------------------------------------------------------
    assign w_byte_lsb  = {r_k, 3'b000};
    assign w_beat_addr = r_addr + {30'h0, r_k};   // wraps modulo 2^32
    assign w_beat_byte = r_wdata[w_byte_lsb +: 8];

    assign mem_addr  = r_split ? w_beat_addr : r_addr;
    assign mem_memop = r_split ? (r_we ? OP_B : OP_BU) : r_memop;
    assign mem_wdata = r_split ? {24'h0, w_beat_byte} : r_wdata;
    // Gated by rst directly so a reset landing mid-store stops the write
    // in that very cycle rather than one edge later.
    assign mem_we    = (r_state == S_WR) & ~rst;

    // -------------------------------------------------------------------------
    // Response
    // -------------------------------------------------------------------------
    assign w_load_result = r_split ? extend_split(r_buf, r_memop) : r_buf;

    assign resp_valid = (r_state == S_DONE);
    assign resp_err   = (r_state == S_DONE) & r_err;
    assign resp_rdata = ((r_state == S_DONE) && !r_err && !r_we) ? w_load_result : 32'h0;

    assign split_cnt  = r_split_cnt;

endmodule

// File: tb/tb_lsu_split.sv
module tb_lsu_split;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_memop;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] split_cnt;

    lsu_split dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_memop  (req_memop),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_memop  (mem_memop),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .split_cnt  (split_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dmem model: 1 KiB, address bits [9:0], registered read
    logic [7:0] mem [0:1023];
    logic       mem_init;

    function automatic logic [9:0] ma(input logic [31:0] a, input int off);
        logic [31:0] s;
        s = a + 32'(off);
        return s[9:0];
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
            mem[10'h104] <= 8'h55; mem[10'h105] <= 8'h66; mem[10'h106] <= 8'h77; mem[10'h107] <= 8'h88;
            mem[10'h108] <= 8'h99;
            mem_rdata <= 32'h0;
        end else begin
            case (mem_memop)
                3'b000:  mem_rdata <= {{24{mem[ma(mem_addr,0)][7]}}, mem[ma(mem_addr,0)]};
                3'b001:  mem_rdata <= {{16{mem[ma(mem_addr,1)][7]}}, mem[ma(mem_addr,1)], mem[ma(mem_addr,0)]};
                3'b010:  mem_rdata <= {mem[ma(mem_addr,3)], mem[ma(mem_addr,2)], mem[ma(mem_addr,1)], mem[ma(mem_addr,0)]};
                3'b100:  mem_rdata <= {24'h0, mem[ma(mem_addr,0)]};
                3'b101:  mem_rdata <= {16'h0, mem[ma(mem_addr,1)], mem[ma(mem_addr,0)]};
                default: mem_rdata <= 32'h0;
            endcase
            if (mem_we) begin
                mem[ma(mem_addr,0)] <= mem_wdata[7:0];
                if (mem_memop == 3'b001 || mem_memop == 3'b010) mem[ma(mem_addr,1)] <= mem_wdata[15:8];
                if (mem_memop == 3'b010) begin
                    mem[ma(mem_addr,2)] <= mem_wdata[23:16];
                    mem[ma(mem_addr,3)] <= mem_wdata[31:24];
                end
            end
        end
    end

    // ---------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Per-cycle trace of the dmem interface, entry i = cycle T+1+i
    logic [31:0] tr_addr [$];
    logic [2:0]  tr_op   [$];
    logic        tr_we   [$];
    logic [31:0] tr_wd   [$];

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_memop = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tr_addr.delete(); tr_op.delete(); tr_we.delete(); tr_wd.delete();
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tr_addr.push_back(mem_addr);
            tr_op.push_back(mem_memop);
            tr_we.push_back(mem_we);
            tr_wd.push_back(mem_wdata);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        logic        split;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input int wes, input logic split);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.wes = wes; v.split = split;
        return v;
    endfunction

    localparam int NV = 32;
    vec_t vt [NV];

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    logic [31:0] exp_sc;
    logic [7:0]  sw_bytes [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Memory state at table start: 0x0FE..0x101 = EF BE AD DE, rest preload
        vt[0]  = mk(0, 3'b010, 32'h100, 0, 32'h4433DEAD, 0, 3, 0, 0);
        vt[1]  = mk(0, 3'b010, 32'h102, 0, 32'h66554433, 0, 9, 0, 1);
        vt[2]  = mk(0, 3'b001, 32'h107, 0, 32'hFFFF9988, 0, 5, 0, 1);
        vt[3]  = mk(0, 3'b101, 32'h107, 0, 32'h00009988, 0, 5, 0, 1);
        vt[4]  = mk(0, 3'b000, 32'h107, 0, 32'hFFFFFF88, 0, 3, 0, 0);
        vt[5]  = mk(0, 3'b100, 32'h107, 0, 32'h00000088, 0, 3, 0, 0);
        vt[6]  = mk(0, 3'b001, 32'h104, 0, 32'h00006655, 0, 3, 0, 0);
        vt[7]  = mk(0, 3'b001, 32'h106, 0, 32'hFFFF8877, 0, 3, 0, 0);
        vt[8]  = mk(0, 3'b010, 32'h101, 0, 32'h554433DE, 0, 9, 0, 1);
        vt[9]  = mk(0, 3'b101, 32'h105, 0, 32'h00007766, 0, 5, 0, 1);
        vt[10] = mk(0, 3'b011, 32'h101, 0, 32'h0, 1, 1, 0, 0);
        vt[11] = mk(1, 3'b100, 32'h103, 32'h55, 32'h0, 1, 1, 0, 0);
        vt[12] = mk(1, 3'b101, 32'h105, 32'h55, 32'h0, 1, 1, 0, 0);
        vt[13] = mk(0, 3'b111, 32'h100, 0, 32'h0, 1, 1, 0, 0);
        vt[14] = mk(0, 3'b001, 32'h0FE, 0, 32'hFFFFBEEF, 0, 3, 0, 0);
        vt[15] = mk(0, 3'b010, 32'h0FF, 0, 32'h33DEADBE, 0, 9, 0, 1);
        vt[16] = mk(1, 3'b001, 32'h103, 32'h00001234, 32'h0, 0, 3, 2, 1);
        vt[17] = mk(0, 3'b010, 32'h104, 0, 32'h88776612, 0, 3, 0, 0);
        vt[18] = mk(0, 3'b010, 32'h100, 0, 32'h3433DEAD, 0, 3, 0, 0);
        vt[19] = mk(1, 3'b000, 32'h108, 32'hFFFFFFAB, 32'h0, 0, 2, 1, 0);
        vt[20] = mk(0, 3'b100, 32'h108, 0, 32'h000000AB, 0, 3, 0, 0);
        vt[21] = mk(0, 3'b000, 32'h108, 0, 32'hFFFFFFAB, 0, 3, 0, 0);
        vt[22] = mk(1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 0, 2, 1, 0);
        vt[23] = mk(0, 3'b010, 32'h10C, 0, 32'hCAFEF00D, 0, 3, 0, 0);
        vt[24] = mk(1, 3'b001, 32'hFFFFFFFF, 32'h00005AA5, 32'h0, 0, 3, 2, 1);
        vt[25] = mk(0, 3'b101, 32'hFFFFFFFF, 0, 32'h00005AA5, 0, 5, 0, 1);
        vt[26] = mk(0, 3'b010, 32'hFFFFFFFD, 0, 32'h5AA50000, 0, 9, 0, 1);
        vt[27] = mk(1, 3'b001, 32'h110, 32'h0000BEEF, 32'h0, 0, 2, 1, 0);
        vt[28] = mk(0, 3'b001, 32'h110, 0, 32'hFFFFBEEF, 0, 3, 0, 0);
        vt[29] = mk(1, 3'b010, 32'h111, 32'h01020304, 32'h0, 0, 5, 4, 1);
        vt[30] = mk(0, 3'b010, 32'h110, 0, 32'h020304EF, 0, 3, 0, 0);
        vt[31] = mk(0, 3'b101, 32'h113, 0, 32'h00000102, 0, 5, 0, 1);

        sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;

        req_valid = 1'b0; req_we = 1'b0; req_memop = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        rst = 1'b1;
        mem_init = 1'b1;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        chk("we_in_reset", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_memop", 32'(mem_memop), 32'd0);
        chk("rst_split_cnt", split_cnt, 32'h0);

        // ---- split lw 0x102 address/memop trace
        do_req(1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat);
        chk("trace_lw_lat", 32'(lat), 32'd9);
        chk("trace_lw_rdata", rd, 32'h66554433);
        for (int i = 0; i < 8; i++) begin
            if (i < tr_addr.size()) begin
                chk($sformatf("trace_lw_addr[%0d]", i), tr_addr[i], 32'h102 + 32'(i / 2));
                chk($sformatf("trace_lw_op[%0d]", i), 32'(tr_op[i]), 32'd4);
                chk($sformatf("trace_lw_we[%0d]", i), 32'(tr_we[i]), 32'd0);
            end
        end
        chk("trace_lw_split_cnt", split_cnt, 32'd1);

        // ---- reset in the third WR cycle of a split sw 0x0FE
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
        req_addr = 32'h0FE; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rststore_we_c1", 32'(mem_we), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rststore_we_c3", 32'(mem_we), 32'd0);
        chk("rststore_resp_c3", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rststore_ready", 32'(req_ready), 32'd1);
        chk("rststore_resp", 32'(resp_valid), 32'd0);
        chk("rststore_split_cnt", split_cnt, 32'h0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("rststore_lw_lat", 32'(lat), 32'd3);
        chk("rststore_lw_rdata", rd, 32'h44332211);
        wes = 0;
        foreach (tr_we[i]) if (tr_we[i]) wes++;
        chk("aligned_lw_we", 32'(wes), 32'd0);

        // ---- full split sw 0x0FE
        do_req(1'b1, 3'b010, 32'h0FE, 32'hDEADBEEF, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_rdata", rd, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i < tr_addr.size()) begin
                chk($sformatf("sw_we[%0d]", i), 32'(tr_we[i]), 32'd1);
                chk($sformatf("sw_addr[%0d]", i), tr_addr[i], 32'h0FE + 32'(i));
                chk($sformatf("sw_byte[%0d]", i), 32'(tr_wd[i][7:0]), 32'(sw_bytes[i]));
                chk($sformatf("sw_op[%0d]", i), 32'(tr_op[i]), 32'd0);
            end
        end
        if (tr_we.size() > 4) chk("sw_we_done", 32'(tr_we[4]), 32'd0);
        chk("sw_split_cnt", split_cnt, 32'd1);
        exp_sc = 32'd1;

        // ---- table
        for (int v = 0; v < NV; v++) begin
            do_req(vt[v].we, vt[v].op, vt[v].addr, vt[v].wdata, rd, er, lat);
            wes = 0;
            foreach (tr_we[i]) if (tr_we[i]) wes++;
            if (vt[v].split) exp_sc = exp_sc + 32'd1;
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vt[v].lat));
            chk($sformatf("v%0d_rdata", v), rd, vt[v].rdata);
            chk($sformatf("v%0d_err", v), 32'(er), 32'(vt[v].err));
            chk($sformatf("v%0d_we_cycles", v), 32'(wes), 32'(vt[v].wes));
            chk($sformatf("v%0d_split_cnt", v), split_cnt, exp_sc);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_split.md
# lsu_split

Load/store sequencer between the CPU memory stage and `dmem`. Accepts one load or store request at a time, drives the `dmem` address, data, memop and write-enable, and returns the formatted load result or store completion. A naturally aligned access is passed through as a single `dmem` access. A misaligned halfword or word access is split into consecutive byte accesses, and the bytes are merged and sign- or zero-extended before the response.

## Interface
Parameters: none.

- `clk`  in  1  system clock; `dmem` `rdclk` and `wrclk` are both tied to `clk` (rising edge)
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_memop`  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse, for loads and stores
- `resp_rdata`  out  32  load result, extended; 0 for stores
- `resp_err`  out  1  illegal memop, valid with `resp_valid`
- `mem_addr`  out  32  drives both `dmem` `rdaddr` and `wraddr`
- `mem_wdata`  out  32  `dmem` `datain`
- `mem_memop`  out  3  `dmem` `memop`
- `mem_we`  out  1  `dmem` `we`
- `mem_rdata`  in  32  `dmem` `dataout`
- `split_cnt`  out  32  count of accepted misaligned (split) requests, wraps

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE. `req_ready` = (state == IDLE) & !rst.
- On accept, register `we`, `memop`, `addr` and `wdata`.
  - Misaligned means: h/hu with `addr[0]` = 1, or w with `addr[1:0]` != 0.
  - Beat count n: 1 if aligned (byte accesses are always aligned); 2 for a split halfword; 4 for a split word.
  - Beat counter k runs 0..n-1.
- Aligned beats:
  - `mem_memop` = the original memop.
  - `mem_addr` = addr.
  - `mem_wdata` = wdata.
- Split beats:
  - `mem_addr` = addr + k, modulo 2^32 (wraps 0xFFFFFFFF -> 0x00000000).
  - `mem_memop` = 100 (bu) for loads, 000 (b) for stores.
  - Store: `mem_wdata[7:0]` = wdata[8k+7:8k].
- Load beat:
  - RD_ISSUE: address presented.
  - RD_WAIT: address and memop held; `mem_rdata` valid and captured.
  - Then k+1, next beat in RD_ISSUE, or DONE after beat n-1.
- Split merge: byte k goes to `buf[8k+7:8k]`. At DONE:
  - h: sign-extend `buf[15:0]`; hu: zero-extend `buf[15:0]`.
  - w: `buf`.
  - Aligned: `mem_rdata` is passed unchanged.
- Store beat: one WR cycle per byte with `mem_we` = 1. After beat n-1, go to DONE.
- Illegal memop (011, 110, 111, or store with 100/101): go straight to DONE with `resp_err` = 1 and `resp_rdata` = 0. No `dmem` access; `split_cnt` unchanged.
- DONE: `resp_valid` = 1, then IDLE.
- `split_cnt` increments on accept of a legal misaligned request.
- `mem_we` is forced to 0 whenever `rst` = 1.

## Timing
- Request accepted at the end of cycle T.
- Aligned load: RD_ISSUE T+1, RD_WAIT T+2, `resp_valid` T+3.
- Split load: 2n cycles after accept, `resp_valid` at T+1+2n (T+5 halfword, T+9 word).
- Aligned store: WR T+1, `resp_valid` T+2.
- Split store: `mem_we` high for n consecutive cycles, `resp_valid` at T+1+n.
- Illegal memop: `resp_valid` at T+1.
- Next request can be accepted at T+(latency+1) at the earliest (IDLE cycle). `resp_rdata` and `resp_err` are valid only while `resp_valid` = 1.
- Reset, applied in any state, gives at the next edge:
  - state IDLE;
  - `resp_valid`, `resp_err`, `mem_we` = 0;
  - `resp_rdata`, `mem_addr`, `mem_wdata`, `mem_memop`, `split_cnt` = 0.
- Reset mid-transaction: no response; bytes already written stay written; the pending request is dropped.
- `req_valid` while not ready is ignored. The requester holds it until accepted.

## Test plan
Memory preload for all scenarios: 0x100 = 0x44332211, 0x104 = 0x88776655, 0x108 = 0x00000099.
- Aligned `lw` 0x100, accepted at T:
  - `resp_valid` at T+3, `resp_rdata` = 0x44332211;
  - `mem_we` never high; `split_cnt` stays 0.
- Split `lw` 0x102:
  - `mem_addr` sequence 0x102, 0x103, 0x104, 0x105, each held 2 cycles with `mem_memop` = 100;
  - `resp_rdata` = 0x66554433 at T+9; `split_cnt` = 1.
- Split `lh` 0x107 gives 0xFFFF9988 at T+5. Split `lhu` 0x107 gives 0x00009988. Aligned `lb` 0x107 gives 0xFFFFFF88 at T+3.
- Split `sw` 0x0FE, data 0xDEADBEEF:
  - `mem_we` high T+1..T+4 at 0x0FE..0x101 with bytes EF, BE, AD, DE; `resp_valid` at T+5;
  - a following `lw` 0x100 returns 0x4433DEAD.
- Reset mid-store:
  - same store as above, with `rst` high in the third WR cycle;
  - `mem_we` = 0 in that cycle; no `resp_valid`; `req_ready` = 1 in the cycle after `rst` drops;
  - `lw` 0x100 returns 0x44332211 (only 0x0FE and 0x0FF written).
- Illegal `req_memop` = 011:
  - `resp_valid` and `resp_err` = 1 at T+1, `resp_rdata` = 0;
  - no `mem_we`; `split_cnt` unchanged.
